vote_session_ctrl: RTL

VOTE_SESSION_CTRL -- requirements
Module: vote_session_ctrl

---
 rtl/vote_pkg.sv | 25 ++
 rtl/vote_session_ctrl_if.sv | 25 ++
 rtl/vote_tally.sv | 21 ++
 rtl/vote_session_ctrl.sv | 90 +++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared types and constants for the four-voter ballot controller.
// The verdict encoding is one-hot so downstream logic can decode it without comparators.
package vote_pkg;

   localparam int N_VOTERS = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_OPEN   = 2'd1,
      ST_TALLY  = 2'd2,
      ST_REPORT = 2'd3
   } state_e;

   localparam logic [2:0] RES_FAIL = 3'b100;
   localparam logic [2:0] RES_TIE  = 3'b010;
   localparam logic [2:0] RES_PASS = 3'b001;

   function automatic logic [2:0] count_ones(input logic [N_VOTERS-1:0] mask);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < N_VOTERS; i++) n = n + 3'(mask[i]);
      return n;
   endfunction

endpackage

// File: rtl/vote_session_ctrl_if.sv
// Ballot bus between a requester (master) and the session controller (slave).
// The master opens sessions and presents votes; the slave returns acks, status and the verdict.
interface vote_session_ctrl_if;
   import vote_pkg::*;

   logic                start;
   logic [N_VOTERS-1:0] vote_valid;
   logic [N_VOTERS-1:0] vote_yes;
   logic [N_VOTERS-1:0] vote_ack;
   logic [N_VOTERS-1:0] voted;
   logic                busy;
   logic                done;
   logic [2:0]          result;

   modport master (
      output start, vote_valid, vote_yes,
      input  vote_ack, voted, busy, done, result
   );

   modport slave (
      input  start, vote_valid, vote_yes,
      output vote_ack, voted, busy, done, result
   );

endinterface

// File: rtl/vote_tally.sv
// Combinational verdict: counts yes bits and maps the count to the one-hot result.
// Fewer than two yes fails, exactly two ties, three or more passes.
module vote_tally
   import vote_pkg::*;
(
   input  logic [N_VOTERS-1:0] i_yes_mask,
   output logic [2:0]          o_result
);

   logic [2:0] w_count;

   assign w_count = count_ones(i_yes_mask);

   always_comb begin
      // NOTE: give every output a default first so no latch is inferred.
      o_result = RES_FAIL;
      if (w_count == 3'd2)      o_result = RES_TIE;
      else if (w_count > 3'd2)  o_result = RES_PASS;
   end

endmodule

// File: rtl/vote_session_ctrl.sv
// Ballot session controller: opens a timed voting window, accepts one vote per voter,
// then tallies and reports a one-hot verdict with a single done pulse.
module vote_session_ctrl
   import vote_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
)(
   input  logic                clk,
   input  logic                rst,
   vote_session_ctrl_if.slave  bus
);

   localparam int              TW         = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]   TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] S_IDLE   = ST_IDLE;
   localparam logic [1:0] S_OPEN   = ST_OPEN;
   localparam logic [1:0] S_TALLY  = ST_TALLY;
   localparam logic [1:0] S_REPORT = ST_REPORT;

   logic [1:0]          r_state;
   logic [TW-1:0]       r_timer;
   logic [N_VOTERS-1:0] r_voted;
   logic [N_VOTERS-1:0] r_yes;
   logic [N_VOTERS-1:0] r_ack;
   logic                r_done;
   logic [2:0]          r_result;

   logic [N_VOTERS-1:0] w_accept;
   logic [N_VOTERS-1:0] w_voted_next;
   logic [N_VOTERS-1:0] w_yes_next;
   logic [N_VOTERS-1:0] w_yes_masked;
   logic [2:0]          w_verdict;

   // Only first-time voters are accepted, and only while the window is open.
   assign w_accept     = (r_state == S_OPEN) ? (bus.vote_valid & ~r_voted) : '0;
   assign w_voted_next = r_voted | w_accept;
   assign w_yes_next   = (r_yes & ~w_accept) | (bus.vote_yes & w_accept);
   assign w_yes_masked = r_yes & r_voted;

   vote_tally u_tally (
      .i_yes_mask (w_yes_masked),
      .o_result   (w_verdict)
   );

   always_ff @(posedge clk) begin
      // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         r_state  <= S_IDLE;
         r_timer  <= '0;
         r_voted  <= '0;
         r_yes    <= '0;
         r_ack    <= '0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         r_ack  <= w_accept;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_state <= S_OPEN;
                  r_voted <= '0;
                  r_yes   <= '0;
                  r_timer <= TIMER_LOAD;
               end
            end
            S_OPEN: begin
               r_voted <= w_voted_next;
               r_yes   <= w_yes_next;
               if (&w_voted_next || r_timer == '0) r_state <= S_TALLY;
               else                                r_timer <= r_timer - TW'(1);
            end
            S_TALLY: begin
               r_result <= w_verdict;
               r_done   <= 1'b1;
               r_state  <= S_REPORT;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.vote_ack = r_ack;
   assign bus.voted    = r_voted;
   assign bus.busy     = (r_state != S_IDLE);
   assign bus.done     = r_done;
   assign bus.result   = r_result;

endmodule
